fir_mac_seq: RTL and testbench

- Time-multiplexed FIR compute engine that consumes the parallel tap outputs of the team's 16-bit sample delay line.
- Each time a new sample is shifted in, it snapshots all N taps and coefficients and runs N serial multiply-accumulates on a single multiplier.
- It then rounds and saturates the accumulator to a 16-bit output sample and presents it on a valid/ready output interface.
- It sits between the delay line and the downstream sample sink (DAC or capture logic).

---
 rtl/fir_mac_seq.sv | 134 +++++++++++++
 tb/tb_fir_mac_seq.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/fir_mac_seq.sv
// Time-multiplexed FIR engine: snapshots N delay-line taps and coefficients per sample,
// runs N serial MACs on one multiplier, then rounds/saturates to a 16-bit valid/ready output.
module fir_mac_seq #(
  parameter int N         = 8,
  parameter int ACC_W     = 40,
  parameter int OUT_SHIFT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [16*N-1:0]   taps,
  input  logic [16*N-1:0]   coefs,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [15:0]       out_data,
  output logic              busy,
  output logic              overrun
);

  localparam int IDX_W = $clog2(N);
  localparam logic signed [ACC_W-1:0] RND_BIAS = ACC_W'(1) << (OUT_SHIFT - 1);
  localparam logic signed [ACC_W-1:0] SAT_MAX  = ACC_W'(32'sd32767);
  localparam logic signed [ACC_W-1:0] SAT_MIN  = ACC_W'(-32'sd32768);

  typedef enum logic [2:0] {IDLE, LOAD, MAC, ROUND, HOLD} state_t;

  state_t                    state_reg, state_next;
  logic signed [ACC_W-1:0]   acc_reg;
  logic [IDX_W-1:0]          idx_reg;
  logic                      out_valid_reg;
  logic [15:0]               out_data_reg;
  logic                      overrun_reg;
  logic signed [15:0]        snap_tap  [N];
  logic signed [15:0]        snap_coef [N];

  logic                      accept;
  logic                      last_mac;
  logic signed [31:0]        prod;
  logic signed [ACC_W-1:0]   prod_ext;
  logic signed [ACC_W-1:0]   rnd_sum;
  logic signed [ACC_W-1:0]   rnd_shift;
  logic [15:0]               sat_val;

  // HOLD always has out_valid high, so out_ready alone completes the handshake there.
  assign accept   = in_valid && ((state_reg == IDLE) || ((state_reg == HOLD) && out_ready));
  assign last_mac = (idx_reg == IDX_W'(N - 1));

  assign prod      = snap_tap[idx_reg] * snap_coef[idx_reg];
  assign prod_ext  = {{(ACC_W-32){prod[31]}}, prod};
  assign rnd_sum   = acc_reg + RND_BIAS;
  assign rnd_shift = rnd_sum >>> OUT_SHIFT;

  always_comb begin
    sat_val = rnd_shift[15:0];
    if (rnd_shift > SAT_MAX)
      sat_val = 16'h7fff;
    else if (rnd_shift < SAT_MIN)
      sat_val = 16'h8000;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state_reg <= IDLE;
    else
      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (in_valid) state_next = LOAD;
      LOAD:    state_next = MAC;
      MAC:     if (last_mac) state_next = ROUND;
      ROUND:   state_next = HOLD;
      HOLD:    if (out_ready) state_next = in_valid ? LOAD : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state_reg != IDLE);
    out_valid = out_valid_reg;
    out_data  = out_data_reg;
    overrun   = overrun_reg;
  end

  // Snapshot taps/coefs in LOAD so later input changes cannot leak into the running sum.
  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_snap
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          snap_tap[gi]  <= '0;
          snap_coef[gi] <= '0;
        end else if (state_reg == LOAD) begin
          snap_tap[gi]  <= taps[16*gi +: 16];
          snap_coef[gi] <= coefs[16*gi +: 16];
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_reg       <= '0;
      idx_reg       <= '0;
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      overrun_reg   <= 1'b0;
    end else begin
      case (state_reg)
        LOAD: begin
          acc_reg <= '0;
          idx_reg <= '0;
        end
        MAC: begin
          acc_reg <= acc_reg + prod_ext;
          idx_reg <= idx_reg + IDX_W'(1);
        end
        ROUND: begin
          out_data_reg  <= sat_val;
          out_valid_reg <= 1'b1;
        end
        HOLD: begin
          if (out_ready)
            out_valid_reg <= 1'b0;
        end
        default: ;
      endcase
      if (in_valid && !accept)
        overrun_reg <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fir_mac_seq.sv
// Scoreboard bench for fir_mac_seq: stimulus pushes expected samples, a negedge monitor
// pops and compares on every output handshake.
module tb_fir_mac_seq;
  localparam int N = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic [16*N-1:0]   taps;
  logic [16*N-1:0]   coefs;
  logic              out_ready;
  logic              out_valid;
  logic [15:0]       out_data;
  logic              busy;
  logic              overrun;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  int exp_q[$];

  fir_mac_seq #(.N(N), .ACC_W(40), .OUT_SHIFT(15)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .taps(taps), .coefs(coefs),
    .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data),
    .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end else
      $display("ok   %s: %0d", name, act);
  endtask

  // Monitor: one pop per output handshake.
  always @(negedge clk) begin
    if (rst === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL sb_unexpected: got output %0d, expected no output", $signed(out_data));
      end else
        chk("sb_out_data", $signed(out_data), exp_q.pop_front());
    end
  end

  function automatic logic [16*N-1:0] slot0(input int v);
    logic [16*N-1:0] r;
    r = '0;
    r[15:0] = 16'(v);
    return r;
  endfunction

  function automatic logic [16*N-1:0] fill(input int v);
    logic [16*N-1:0] r;
    for (int k = 0; k < N; k++) r[16*k +: 16] = 16'(v);
    return r;
  endfunction

  function automatic int gold(input logic [16*N-1:0] tv, input logic [16*N-1:0] cv);
    longint s;
    s = 0;
    for (int k = 0; k < N; k++)
      s += longint'($signed(tv[16*k +: 16])) * longint'($signed(cv[16*k +: 16]));
    s = (s + 16384) >>> 15;
    if (s > 32767) s = 32767;
    if (s < -32768) s = -32768;
    return int'(s);
  endfunction

  task automatic scramble();
    for (int k = 0; k < N; k++) begin
      taps[16*k +: 16]  = 16'($urandom);
      coefs[16*k +: 16] = 16'($urandom);
    end
  endtask

  // Strobe from IDLE/HOLD, let LOAD capture, then trash the inputs.
  task automatic start(input logic [16*N-1:0] tv, input logic [16*N-1:0] cv, input int e);
    taps  = tv;
    coefs = cv;
    exp_q.push_back(e);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    scramble();
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (out_valid !== 1'b1 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    if (out_valid !== 1'b1) chk("wait_valid_timeout", out_valid, 1);
  endtask

  task automatic run_simple(input string name, input logic [16*N-1:0] tv,
                            input logic [16*N-1:0] cv, input int e);
    int n;
    out_ready = 1'b1;
    start(tv, cv, e);
    wait_valid(n);
    chk({name, "_latency"}, n + 1, N + 2);
    @(posedge clk); #1;
    chk({name, "_pulse_end"}, out_valid, 0);
    chk({name, "_idle"}, busy, 0);
  endtask

  logic [16*N-1:0] tv_b2b [8];
  logic [16*N-1:0] cv_b2b [8];

  initial begin
    int n;
    int prev;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; taps = '0; coefs = '0;
    #12;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", $signed(out_data), 0);
    chk("rst_busy", busy, 0);
    chk("rst_overrun", overrun, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    run_simple("impulse", slot0(16384), slot0(16384), 8192);
    run_simple("rnd_1_16384", slot0(1), slot0(16384), 1);
    run_simple("rnd_1_16383", slot0(1), slot0(16383), 0);
    run_simple("rnd_m1_16384", slot0(-1), slot0(16384), 0);
    run_simple("rnd_m3_16384", slot0(-3), slot0(16384), -1);
    run_simple("sat_pos", fill(32767), fill(32767), 32767);
    run_simple("sat_neg", fill(-32768), fill(32767), -32768);
    chk("sat_overrun", overrun, 0);

    // Back-to-back with a strobe exactly on each handshake edge.
    for (int i = 0; i < 8; i++)
      for (int k = 0; k < N; k++) begin
        tv_b2b[i][16*k +: 16] = 16'((i + 1) * 1000 * ((k % 2 == 1) ? -1 : 1) + k * 37);
        cv_b2b[i][16*k +: 16] = 16'(4096 - k * 900 + i * 11);
      end
    out_ready = 1'b1;
    start(tv_b2b[0], cv_b2b[0], gold(tv_b2b[0], cv_b2b[0]));
    wait_valid(n);
    prev = cyc;
    for (int i = 1; i < 8; i++) begin
      start(tv_b2b[i], cv_b2b[i], gold(tv_b2b[i], cv_b2b[i]));
      wait_valid(n);
      chk("b2b_period", cyc - prev, N + 3);
      prev = cyc;
    end
    @(posedge clk); #1;
    chk("b2b_end_valid", out_valid, 0);
    chk("b2b_end_busy", busy, 0);
    chk("b2b_overrun", overrun, 0);

    // Backpressure with a dropped strobe in HOLD.
    out_ready = 1'b0;
    start(slot0(1000), slot0(16384), 500);
    wait_valid(n);
    for (int i = 0; i < 5; i++) begin
      chk("bp_hold_valid", out_valid, 1);
      chk("bp_hold_data", $signed(out_data), 500);
      if (i == 2) in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
    end
    chk("bp_overrun", overrun, 1);
    chk("bp_busy", busy, 1);
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_after_valid", out_valid, 0);
    chk("bp_after_busy", busy, 0);

    // Reset in the middle of MAC; the aborted result is never queued.
    taps = slot0(2000); coefs = slot0(16384);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    rst = 1'b1;
    #1;
    chk("mrst_out_valid", out_valid, 0);
    chk("mrst_out_data", $signed(out_data), 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_overrun", overrun, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    chk("mrst_quiet", out_valid, 0);
    run_simple("post_rst", slot0(-2000), slot0(16384), -1000);

    repeat (3) begin @(posedge clk); #1; end
    chk("sb_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
